// File: rtl/bcd_stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// bcd_stopwatch_pkg
// Shared definitions for the BCD stopwatch:
//   state_t       : FSM encoding (IDLE / RUN / PAUSE)
//   SEC_TENS_MAX  : highest value of the seconds-tens digit
//   DIGIT_MAX     : highest value of a plain decimal digit
//   to_bcd2()     : converts a 0..99 integer into two packed BCD digits
// -----------------------------------------------------------------------------
package bcd_stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam logic [3:0] SEC_TENS_MAX = 4'd5;
   localparam logic [3:0] DIGIT_MAX    = 4'd9;

   // {tens, ones} of a value in 0..99; used at elaboration time to turn the
   // MIN_MAX parameter into a BCD compare constant.
   function automatic logic [7:0] to_bcd2(input int value);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(value / 10);
      ones = 4'(value % 10);
      return {tens, ones};
   endfunction

endpackage

// File: rtl/bcd_stopwatch_digit_counter.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
// One BCD digit that counts 0..LIMIT and rolls back to 0.
// Ports:
//   clock  : system clock
//   reset  : asynchronous active-high reset, digit -> 0
//   clr    : synchronous clear, wins over inc
//   inc    : advance by one on this edge
//   digit  : current digit value (registered)
//   carry  : combinational, high when inc is high and digit == LIMIT, i.e. this
//            digit is about to roll over and the next digit must advance
// -----------------------------------------------------------------------------
module bcd_digit_counter #(
   parameter logic [3:0] LIMIT = 4'd9
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] digit,
   output logic       carry
);

   logic [3:0] digit_reg;
   logic       at_limit;

   assign at_limit = (digit_reg == LIMIT);
   assign carry    = inc & at_limit;
   assign digit    = digit_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         digit_reg <= 4'd0;
      end else if (clr) begin
         digit_reg <= 4'd0;
      end else if (inc) begin
         digit_reg <= at_limit ? 4'd0 : digit_reg + 4'd1;
      end
   end

endmodule

// File: rtl/bcd_stopwatch.sv
// -----------------------------------------------------------------------------
// bcd_stopwatch
// Start/stop/clear MM:SS stopwatch in BCD, counting rising edges of the
// divided clock level tick_in (sampled as data in the clock domain).
//
// Parameters:
//   MIN_MAX        : highest minute value before wrapping to 00:00 (1..99)
//   TICKS_PER_SEC  : tick_in rising edges per counted second
//
// Ports:
//   clock, reset   : system clock, asynchronous active-high reset
//   tick_in        : divided-clock level
//   start_stop     : 1-cycle pulse, toggles run / pause (starts from idle)
//   clear          : 1-cycle pulse, back to 00:00 stopped (highest priority)
//   lap            : 1-cycle pulse, display freeze toggle (LAP_HOLD_EN only)
//   sec_ones, sec_tens, min_ones, min_tens : displayed BCD digits
//   running        : high while in RUN
//   wrap           : 1-cycle pulse after the count wraps MIN_MAX:59 -> 00:00
//
// Build option:
//   LAP_HOLD_EN    : when defined, a lap pulse in RUN freezes the display
//                    while counting continues; a second lap, leaving RUN or
//                    clear releases it. When undefined lap is ignored.
// -----------------------------------------------------------------------------
module bcd_stopwatch
   import bcd_stopwatch_pkg::*;
#(
   parameter int MIN_MAX       = 59,
   parameter int TICKS_PER_SEC = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick_in,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       running,
   output logic       wrap
);

   localparam int         PW          = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [7:0] MIN_MAX_BCD = to_bcd2(MIN_MAX);
   localparam logic [3:0] MIN_MAX_T   = MIN_MAX_BCD[7:4];
   localparam logic [3:0] MIN_MAX_O   = MIN_MAX_BCD[3:0];

   state_t        state_reg;
   logic          running_reg;
   logic          wrap_reg;
   logic          tick_d;
   logic [PW-1:0] presc_reg;

   logic          tick_rise;
   logic          in_run;
   logic          presc_last;
   logic          sec_step;
   logic          min_at_max;
   logic          wrap_evt;
   logic          digit_clr;

   // Live digits, index 0 = sec_ones .. 3 = min_tens
   logic [3:0]    digit_live [4];
   logic [3:0]    disp       [4];
   logic [3:0]    inc_vec;
   logic [3:0]    carry_vec;

   assign tick_rise  = tick_in & ~tick_d;
   assign in_run     = (state_reg == ST_RUN);
   assign presc_last = (presc_reg == PW'(TICKS_PER_SEC - 1));
   // Counting is decided by the current state, so a tick coinciding with
   // IDLE->RUN is dropped while one coinciding with RUN->PAUSE still counts.
   assign sec_step   = in_run & tick_rise & presc_last & ~clear;

   assign min_at_max = (digit_live[3] == MIN_MAX_T) && (digit_live[2] == MIN_MAX_O);
   // carry_vec[1] means "xx:59 and stepping", so this is MIN_MAX:59 + 1.
   assign wrap_evt   = carry_vec[1] & min_at_max;
   // A carry out of the minutes-tens digit can only coincide with the
   // MIN_MAX wrap for legal MIN_MAX; folding it in keeps the count bounded.
   assign digit_clr  = clear | wrap_evt | carry_vec[3];

   // Ripple chain: each digit advances on the carry of the one below it.
   assign inc_vec = {carry_vec[2:0], sec_step};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         localparam logic [3:0] LIM = (gi == 1) ? SEC_TENS_MAX : DIGIT_MAX;
         bcd_digit_counter #(
            .LIMIT (LIM)
         ) u_digit (
            .clock (clock),
            .reset (reset),
            .clr   (digit_clr),
            .inc   (inc_vec[gi]),
            .digit (digit_live[gi]),
            .carry (carry_vec[gi])
         );
      end
   endgenerate

   // Control FSM, edge detector, prescaler and registered status outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         running_reg <= 1'b0;
         wrap_reg    <= 1'b0;
         tick_d      <= 1'b0;
         presc_reg   <= '0;
      end else begin
         tick_d   <= tick_in;
         wrap_reg <= wrap_evt;
         if (clear) begin
            state_reg   <= ST_IDLE;
            running_reg <= 1'b0;
            presc_reg   <= '0;
         end else begin
            if (in_run && tick_rise) begin
               presc_reg <= presc_last ? '0 : presc_reg + PW'(1);
            end
            if (start_stop) begin
               case (state_reg)
                  ST_IDLE, ST_PAUSE: begin
                     state_reg   <= ST_RUN;
                     running_reg <= 1'b1;
                  end
                  ST_RUN: begin
                     state_reg   <= ST_PAUSE;
                     running_reg <= 1'b0;
                  end
                  default: begin
                     state_reg   <= ST_IDLE;
                     running_reg <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

`ifdef LAP_HOLD_EN
   logic       freeze_reg;
   logic [3:0] hold_reg [4];
   logic       leave_run;

   // Any way out of RUN (pause or clear) drops the freeze.
   assign leave_run = in_run & (clear | start_stop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         freeze_reg <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            hold_reg[i] <= 4'd0;
         end
      end else if (leave_run) begin
         freeze_reg <= 1'b0;
      end else if (in_run && lap) begin
         if (freeze_reg) begin
            freeze_reg <= 1'b0;
         end else begin
            freeze_reg <= 1'b1;
            for (int i = 0; i < 4; i++) begin
               hold_reg[i] <= digit_live[i];
            end
         end
      end
   end

   generate
      for (gi = 0; gi < 4; gi++) begin : g_disp
         assign disp[gi] = freeze_reg ? hold_reg[gi] : digit_live[gi];
      end
   endgenerate
`else
   logic lap_unused;
   assign lap_unused = lap;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_disp
         assign disp[gi] = digit_live[gi];
      end
   endgenerate
`endif

   assign sec_ones = disp[0];
   assign sec_tens = disp[1];
   assign min_ones = disp[2];
   assign min_tens = disp[3];
   assign running  = running_reg;
   assign wrap     = wrap_reg;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// -----------------------------------------------------------------------------
// tb_bcd_stopwatch
// Scoreboard bench for bcd_stopwatch. Each stimulus cycle advances a
// reference model kept as elapsed seconds (plus mode and lap snapshot) and
// queues the display it implies; a monitor pops one entry per cycle on the
// falling edge and compares it with the DUT outputs.
// Honors LAP_HOLD_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_bcd_stopwatch;

   localparam int MIN_MAX       = 2;
   localparam int TPS           = 1;
   localparam int MAX_TOT       = MIN_MAX * 60 + 59;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       tick_in = 1'b0;
   logic       start_stop = 1'b0;
   logic       clear = 1'b0;
   logic       lap = 1'b0;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic       running, wrap;

   always #5 clock = ~clock;

   bcd_stopwatch #(
      .MIN_MAX       (MIN_MAX),
      .TICKS_PER_SEC (TPS)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .tick_in    (tick_in),
      .start_stop (start_stop),
      .clear      (clear),
      .lap        (lap),
      .sec_ones   (sec_ones),
      .sec_tens   (sec_tens),
      .min_ones   (min_ones),
      .min_tens   (min_tens),
      .running    (running),
      .wrap       (wrap)
   );

   typedef struct {
      logic [15:0] digits;
      logic        run;
      logic        wrp;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: elapsed seconds, not digits.
   int   m_mode = 0;      // 0 idle, 1 run, 2 pause
   int   m_total = 0;
   int   m_presc = 0;
   int   m_held = 0;
   bit   m_frozen = 0;
   bit   m_prev_tick = 0;
   bit   m_wrap = 0;
   logic tick_lvl = 1'b0;

   function automatic logic [15:0] to_digits(input int t);
      int s, m;
      s = t % 60;
      m = t / 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [15:0] dut_digits();
      return {min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_total = 0; m_presc = 0; m_held = 0;
      m_frozen = 0; m_prev_tick = 0; m_wrap = 0;
   endtask

   task automatic model_edge(input logic t, input logic ss, input logic cl, input logic lp);
      bit rise, was_run;
      rise = t && !m_prev_tick;
      m_prev_tick = t;
      m_wrap = 0;
      if (cl) begin
         m_mode = 0; m_total = 0; m_presc = 0; m_frozen = 0;
      end else begin
         was_run = (m_mode == 1);
`ifdef LAP_HOLD_EN
         if (was_run && lp) begin
            if (m_frozen) m_frozen = 0;
            else begin
               m_frozen = 1;
               m_held = m_total;
            end
         end
`else
         if (lp) m_frozen = 0;
`endif
         if (was_run && rise) begin
            m_presc++;
            if (m_presc == TPS) begin
               m_presc = 0;
               m_total++;
               if (m_total > MAX_TOT) begin
                  m_total = 0;
                  m_wrap = 1;
               end
            end
         end
         if (ss) m_mode = (m_mode == 1) ? 2 : 1;
         if (m_mode != 1) m_frozen = 0;
      end
   endtask

   // One clock of stimulus; the expected result is queued after the edge.
   task automatic step(input logic t, input logic ss, input logic cl, input logic lp);
      exp_t e;
      tick_in = t; start_stop = ss; clear = cl; lap = lp;
      tick_lvl = t;
      model_edge(t, ss, cl, lp);
      e.digits = to_digits(m_frozen ? m_held : m_total);
      e.run    = (m_mode == 1);
      e.wrp    = m_wrap;
      @(posedge clock);
      #1;
      exp_q.push_back(e);
      start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
   endtask

   task automatic tick_sec(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // Reset asserted between clock edges with tick_in already high.
   task automatic async_reset(input string name);
      @(negedge clock);
      #1;
      reset = 1'b1;
      tick_in = 1'b1;
      tick_lvl = 1'b1;
      #1;
      check({name, "_digits"}, 32'(dut_digits()), 32'h0);
      check({name, "_running"}, 32'(running), 32'h0);
      check({name, "_wrap"}, 32'(wrap), 32'h0);
      model_reset();
      @(posedge clock);
      @(negedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: one comparison set per clock while expectations are pending.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("digits", 32'(dut_digits()), 32'(e.digits));
            check("running", 32'(running), 32'(e.run));
            check("wrap", 32'(wrap), 32'(e.wrp));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic t, ss, cl, lp;

      $display("[TB] phase reset/idle");
      async_reset("reset_init");
      tick_sec(5);

      $display("[TB] phase count 12");
      step(1'b0, 1'b1, 1'b0, 1'b0);
      tick_sec(12);
      check("dir_00_12", 32'(dut_digits()), 32'h0012);
      check("dir_running", 32'(running), 32'h1);

      $display("[TB] phase run to wrap");
      tick_sec(47);
      check("dir_00_59", 32'(dut_digits()), 32'h0059);
      tick_sec(1);
      check("dir_01_00", 32'(dut_digits()), 32'h0100);
      tick_sec(119);
      check("dir_02_59", 32'(dut_digits()), 32'h0259);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("dir_wrap_hi", 32'(wrap), 32'h1);
      check("dir_wrap_digits", 32'(dut_digits()), 32'h0000);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("dir_wrap_lo", 32'(wrap), 32'h0);
      check("dir_wrap_run", 32'(running), 32'h1);

      $display("[TB] phase simultaneous events");
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("dir_start_tick", 32'(dut_digits()), 32'h0000);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      tick_sec(5);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("dir_pause_tick", 32'(dut_digits()), 32'h0006);
      check("dir_pause_run", 32'(running), 32'h0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("dir_clear_ss", 32'(dut_digits()), 32'h0000);
      check("dir_clear_ss_run", 32'(running), 32'h0);

      $display("[TB] phase reset mid-run");
      step(1'b0, 1'b1, 1'b0, 1'b0);
      tick_sec(37);
      check("dir_00_37", 32'(dut_digits()), 32'h0037);
      async_reset("reset_mid");
      tick_sec(3);
      check("dir_after_reset", 32'(dut_digits()), 32'h0000);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      tick_sec(2);
      check("dir_resume", 32'(dut_digits()), 32'h0002);

      $display("[TB] phase lap");
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      tick_sec(3);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      tick_sec(4);
`ifdef LAP_HOLD_EN
      check("dir_lap_hold", 32'(dut_digits()), 32'h0003);
`else
      check("dir_lap_ignored", 32'(dut_digits()), 32'h0007);
`endif
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("dir_lap_release", 32'(dut_digits()), 32'h0007);

      $display("[TB] phase random");
      for (int blk = 0; blk < 3; blk++) begin
         for (int i = 0; i < 1000; i++) begin
            t  = 1'($urandom_range(0, 1));
            ss = ($urandom_range(0, 39) == 0);
            cl = ($urandom_range(0, 199) == 0);
            lp = ($urandom_range(0, 29) == 0);
            step(t, ss, cl, lp);
         end
         $display("[TB] random block %0d done", blk);
         async_reset("reset_rand");
      end
      tick_sec(2);

      @(negedge clock);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
